// File: rtl/pool_pkg.sv
// Shared types and sizing helpers for the pooled-result buffer.
// DEPTH is the pooled map size: every 2x2 input window becomes one sample per channel.
package pool_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  function automatic int calc_depth(input int width, input int height, input int channel);
    return channel * height * width / 4;
  endfunction

  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pool_fmap_mem.sv
// Pooled feature-map storage: DEPTH x DATA_W register file.
// It has one synchronous write port and one combinational read port.
module pool_fmap_mem
  import pool_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int AW    = addr_bits(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the memory is cleared on reset because a drain straight after reset must read 0x00.
  // This rules out inferring block RAM, which is acceptable at DEPTH <= 256.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool_result_buffer.sv
// Buffers one layer of pooled samples, then streams it out in index order with valid/ready.
// The buffer fills while in FILL; a rising edge of pool_fin starts a single DRAIN pass.
module pool_result_buffer
  import pool_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int HEIGHT  = 2,
  parameter int CHANNEL = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pool_fin,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              error
);

  localparam int                DEPTH     = calc_depth(WIDTH, HEIGHT, CHANNEL);
  localparam int                MEM_AW    = addr_bits(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic              pool_fin_q;
  logic              in_range;
  logic              fin_rise;
  logic              mem_we;
  logic [ADDR_W-1:0] rd_idx;
  logic [DATA_W-1:0] rd_data;

  assign in_range = ({1'b0, wr_addr} < DEPTH_EXT);
  assign fin_rise = pool_fin & ~pool_fin_q;
  assign mem_we   = (state == ST_FILL) && wr_en && in_range;

  // Before the first beat, point at entry 0; afterwards, prefetch the entry after the current one.
  assign rd_idx   = out_valid ? out_index + ADDR_W'(1) : '0;
  assign busy     = (state == ST_DRAIN);

  pool_fmap_mem #(
    .DEPTH (DEPTH),
    .AW    (MEM_AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .waddr (wr_addr[MEM_AW-1:0]),
    .wdata (wr_data),
    .raddr (rd_idx[MEM_AW-1:0]),
    .rdata (rd_data)
  );

  // NOTE: all state is updated with non-blocking assignments, so every branch reads
  // the values from before the edge. This matches the hardware and avoids ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FILL;
      pool_fin_q <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
      error      <= 1'b0;
    end else begin
      pool_fin_q <= pool_fin;
      if (wr_en && ((state == ST_DRAIN) || !in_range)) error <= 1'b1;

      case (state)
        ST_FILL: begin
          if (fin_rise) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!out_valid || out_ready) begin
            if (out_valid && (out_index == LAST_IDX)) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= ST_FILL;
            end else begin
              out_valid <= 1'b1;
              out_index <= rd_idx;
              out_data  <= rd_data;
              out_last  <= (rd_idx == LAST_IDX);
            end
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_result_buffer.sv
// Scenario bench for pool_result_buffer at WIDTH=4, HEIGHT=4, CHANNEL=2 (DEPTH=8).
// Expected beats are queued from a model of the memory and popped as the DUT transfers them.
module tb_pool_result_buffer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       pool_fin;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [7:0] out_index;
  logic       out_last;
  logic       busy;
  logic       error;

  typedef struct {
    logic [7:0] idx;
    logic [7:0] data;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] model_mem [DEPTH];
  int         errors = 0;
  int         checks = 0;

  pool_result_buffer #(
    .WIDTH   (4),
    .HEIGHT  (4),
    .CHANNEL (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pool_fin  (pool_fin),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .error     (error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    exp_q.delete();
  endtask

  task automatic fill(input logic [7:0] base);
    for (int a = 0; a < DEPTH; a++) begin
      wr_en   = 1'b1;
      wr_addr = 8'(a);
      wr_data = base + 8'(a);
      model_mem[a] = base + 8'(a);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic start_drain(input string tag);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back('{idx: 8'(i), data: model_mem[i]});
    pool_fin = 1'b1;
    tick();
    pool_fin = 1'b0;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_enter: busy=%b out_valid=%b, expected busy=1 out_valid=0", tag, busy, out_valid);
    end
  endtask

  // Walks the stream for up to n_beats transfers. It can alternate out_ready, hold pool_fin,
  // and inject one write on a given cycle.
  task automatic collect(input int n_beats, input bit alt, input int inject_at,
                         input int fin_hold, input string tag);
    int         beats = 0;
    bit         held  = 1'b0;
    logic [7:0] hd, hi;
    logic       hl;
    beat_t      e;
    for (int cyc = 0; cyc < 200 && beats < n_beats; cyc++) begin
      out_ready = alt ? (cyc % 2 == 1) : 1'b1;
      pool_fin  = (cyc < fin_hold);
      if (cyc == inject_at) begin
        wr_en = 1'b1; wr_addr = 8'd2; wr_data = 8'hEE;
      end else begin
        wr_en = 1'b0;
      end
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hd || out_index !== hi || out_last !== hl) begin
          errors++;
          $display("FAIL %s_hold: valid=%b data=%h idx=%0d last=%b, expected 1 %h %0d %b",
                   tag, out_valid, out_data, out_index, out_last, hd, hi, hl);
        end
      end
      held = 1'b0;
      if (out_valid === 1'b1) begin
        checks++;
        if (out_last !== (out_index == 8'(DEPTH - 1))) begin
          errors++;
          $display("FAIL %s_last: out_last=%b at index %0d", tag, out_last, out_index);
        end
        if (out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_extra: beat idx=%0d data=%h with nothing expected", tag, out_index, out_data);
          end else begin
            e = exp_q.pop_front();
            if (out_index !== e.idx || out_data !== e.data) begin
              errors++;
              $display("FAIL %s_beat: idx=%0d data=%h, expected idx=%0d data=%h",
                       tag, out_index, out_data, e.idx, e.data);
            end
          end
          beats++;
        end else begin
          held = 1'b1; hd = out_data; hi = out_index; hl = out_last;
        end
      end
      tick();
    end
    wr_en = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (beats != n_beats) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats, expected %0d", tag, beats, n_beats);
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: valid=%b busy=%b last=%b, expected 0 0 0", tag, out_valid, busy, out_last);
    end
  endtask

  task automatic check_error(input logic want, input string tag);
    checks++;
    if (error !== want) begin
      errors++;
      $display("FAIL %s_error: error=%b, expected %b", tag, error, want);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_index !== 8'h00 ||
        out_last !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h idx=%h last=%b busy=%b err=%b, expected all 0",
               out_valid, out_data, out_index, out_last, busy, error);
    end
  endtask

  task automatic test_full_drain();
    do_reset();
    fill(8'h10);
    start_drain("full");
    collect(DEPTH, 1'b0, -1, 0, "full");
    check_idle("full");
    check_error(1'b0, "full");
  endtask

  task automatic test_backpressure();
    do_reset();
    fill(8'h10);
    start_drain("bp");
    collect(DEPTH, 1'b1, -1, 0, "bp");
    check_idle("bp");
  endtask

  task automatic test_out_of_range();
    do_reset();
    fill(8'h20);
    wr_en = 1'b1; wr_addr = 8'd8; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    check_error(1'b1, "oor");
    start_drain("oor");
    collect(DEPTH, 1'b0, -1, 0, "oor");
    check_idle("oor");
  endtask

  task automatic test_fin_held();
    do_reset();
    fill(8'h30);
    start_drain("held");
    pool_fin = 1'b1;
    collect(DEPTH, 1'b0, -1, 1000, "held");
    for (int i = 0; i < 10; i++) begin
      pool_fin = 1'b1;
      tick();
      check_idle("held_hi");
    end
    pool_fin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("held_lo");
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    fill(8'h40);
    start_drain("mid");
    collect(3, 1'b0, -1, 0, "mid");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid_rst");
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    exp_q.delete();
    start_drain("zero");
    collect(DEPTH, 1'b0, -1, 0, "zero");
    check_idle("zero");
  endtask

  task automatic test_write_in_drain();
    do_reset();
    fill(8'h50);
    start_drain("wid");
    collect(DEPTH, 1'b0, 3, 0, "wid");
    check_error(1'b1, "wid");
    check_idle("wid");
    // The second pass shows that the rejected write did not land in memory.
    start_drain("wid2");
    collect(DEPTH, 1'b0, -1, 0, "wid2");
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pool_fin = 1'b0; out_ready = 1'b1;
    test_reset();
    test_full_drain();
    test_backpressure();
    test_out_of_range();
    test_fin_held();
    test_reset_mid_drain();
    test_write_in_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
